// File: rtl/if_id_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue_pkg
// Description : Shared constants, types and helpers for the IF/ID queue.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_queue_pkg;

  // Default queue depth between fetch and decode
  localparam int c_IFQ_DEPTH = 4;

  // Level of rst that puts the pipeline into its reset state
  localparam logic c_RST_ENABLE = 1'b1;

  // Source selected for the ID output register on an advancing cycle
  typedef enum logic [1:0] {
    SRC_BUBBLE = 2'd0,
    SRC_HEAD   = 2'd1,
    SRC_BYPASS = 2'd2
  } ifq_src_e;

  // Width of one stored {pc, inst} entry
  function automatic int ifq_entry_bus(input int addr_w, input int inst_w);
    return addr_w + inst_w;
  endfunction

endpackage : if_id_queue_pkg
`default_nettype wire

// File: rtl/if_id_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ptr
// Description : Circular-buffer storage with wrapping head/tail pointers and
//               an independent occupancy count, so full and empty never alias.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ptr #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  import if_id_queue_pkg::*;

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [CNT_W-1:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Writes into a full buffer or reads from an empty one are ignored
  assign w_wr = i_push && !w_full;
  assign w_rd = i_pop && !w_empty;

  // Storage has no reset; only the pointers and count define validity
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_tail] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge clk) begin
    if (rst == c_RST_ENABLE || i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_tail <= r_tail + c_PTR_W'(1);
      end
      if (w_rd) begin
        r_head <= r_head + c_PTR_W'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule : sync_fifo_ptr
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : DEPTH-entry instruction queue between fetch and decode with a
//               registered ID output, empty-queue bypass, bubble insertion and
//               single-cycle flush.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = c_IFQ_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  input  logic              id_stall,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic [CNT_W-1:0]  count
);

  localparam int c_ENTRY_W = ifq_entry_bus(ADDR_W, INST_W);

  logic [c_ENTRY_W-1:0] w_wdata;
  logic [c_ENTRY_W-1:0] w_head;
  logic [ADDR_W-1:0]    w_head_pc;
  logic [INST_W-1:0]    w_head_inst;
  logic [CNT_W-1:0]     w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_advance;
  logic                 w_fifo_push;
  logic                 w_fifo_pop;
  ifq_src_e             w_src;

  logic [ADDR_W-1:0]    r_id_pc;
  logic [INST_W-1:0]    r_id_inst;
  logic                 r_id_valid;

  // Ready is derived from registered occupancy only: no pass-through at full
  assign if_ready  = !w_full;

  // flush outranks both the push and the output advance
  assign w_push    = if_valid && !w_full && !flush;
  assign w_advance = !id_stall && !flush;

  // A push into an empty queue on an advancing cycle skips storage entirely
  assign w_fifo_push = w_push && !(w_advance && w_empty);
  assign w_fifo_pop  = w_advance && !w_empty;

  assign w_wdata     = {if_pc, if_inst};
  assign w_head_pc   = w_head[INST_W +: ADDR_W];
  assign w_head_inst = w_head[0 +: INST_W];

  sync_fifo_ptr #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Pick what the output register loads: oldest queued word, bypass, or bubble
  always_comb begin
    w_src = SRC_BUBBLE;
    if (!w_empty) begin
      w_src = SRC_HEAD;
    end else if (w_push) begin
      w_src = SRC_BYPASS;
    end
  end

  // ID output register: cleared by reset/flush, held on stall, else reloaded
  always_ff @(posedge clk) begin
    if (rst == c_RST_ENABLE || flush) begin
      r_id_pc    <= '0;
      r_id_inst  <= '0;
      r_id_valid <= 1'b0;
    end else if (w_advance) begin
      case (w_src)
        SRC_HEAD: begin
          r_id_pc    <= w_head_pc;
          r_id_inst  <= w_head_inst;
          r_id_valid <= 1'b1;
        end
        SRC_BYPASS: begin
          r_id_pc    <= if_pc;
          r_id_inst  <= if_inst;
          r_id_valid <= 1'b1;
        end
        default: begin
          r_id_pc    <= '0;
          r_id_inst  <= '0;
          r_id_valid <= 1'b0;
        end
      endcase
    end
  end

  assign id_pc    = r_id_pc;
  assign id_inst  = r_id_inst;
  assign id_valid = r_id_valid;
  assign count    = w_count;

endmodule : if_id_queue
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_queue
// Description : Scoreboard bench for if_id_queue (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              if_valid = 1'b0;
  logic [ADDR_W-1:0] if_pc = '0;
  logic [INST_W-1:0] if_inst = '0;
  logic              if_ready;
  logic              id_stall = 1'b0;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;
  logic [CNT_W-1:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {pc, inst} words accepted but not yet seen on the ID side
  logic [63:0] sb[$];
  // Expected storage occupancy; -1 until the first reset edge
  int m_count = -1;

  // Monitor state
  bit          mon_adv;
  bit          mon_clr;
  logic        last_v = 1'b0;
  logic [63:0] last_out = '0;
  logic [63:0] mon_exp;

  always #5 clk = ~clk;

  if_id_queue #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .id_stall (id_stall),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid),
    .count    (count)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return (pc * 32'h0000_9E37) ^ 32'h0000_0013;
  endfunction

  // One clock of stimulus; updates the expectation model before the edge
  task automatic step(input logic r, input logic v, input logic [31:0] pc,
                      input logic [31:0] inst, input logic st, input logic fl);
    bit acc;
    bit adv;
    rst      = r;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_stall = st;
    flush    = fl;
    if (m_count >= 0) begin
      check("if_ready", 96'(if_ready), 96'(m_count != DEPTH));
    end
    if (r || fl) begin
      sb.delete();
      m_count = 0;
    end else begin
      acc = v && (m_count != DEPTH);
      adv = !st;
      if (acc) sb.push_back({pc, inst});
      m_count = m_count + ((acc && !(adv && m_count == 0)) ? 1 : 0)
                        - ((adv && m_count > 0) ? 1 : 0);
    end
    @(posedge clk);
    #2;
    check("count", 96'(count), 96'(m_count));
  endtask

  // Monitor: on every edge decide what the ID register must now show
  always @(posedge clk) begin
    mon_adv = !id_stall && !flush && !rst;
    mon_clr = rst || flush;
    #1;
    if (mon_clr) begin
      check("clear_valid", 96'(id_valid), 96'(0));
      check("clear_data", 96'({id_pc, id_inst}), 96'(0));
    end else if (mon_adv) begin
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        check("out_valid", 96'(id_valid), 96'(1));
        check("fifo_order", 96'({id_pc, id_inst}), 96'(mon_exp));
      end else begin
        check("bubble_valid", 96'(id_valid), 96'(0));
        check("bubble_data", 96'({id_pc, id_inst}), 96'(0));
      end
    end else begin
      check("stall_hold", 96'({id_valid, id_pc, id_inst}), 96'({last_v, last_out}));
    end
    last_v   = id_valid;
    last_out = {id_pc, id_inst};
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int cyc;
    bit v;
    bit st;
    logic [31:0] pcs [5];

    // Reset with IF presenting a word: nothing captured
    step(1'b1, 1'b1, 32'hDEAD_0000, 32'hBEEF_0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hDEAD_0004, 32'hBEEF_0004, 1'b0, 1'b0);
    check("rst_id_valid", 96'(id_valid), 96'(0));
    check("rst_id_pc", 96'(id_pc), 96'(0));
    check("rst_count", 96'(count), 96'(0));
    check("rst_if_ready", 96'(if_ready), 96'(1));

    // Bypass: empty queue, no stall
    step(1'b0, 1'b1, 32'h0000_0100, 32'h0050_0093, 1'b0, 1'b0);
    check("bypass_pc", 96'(id_pc), 96'(32'h100));
    check("bypass_inst", 96'(id_inst), 96'(32'h0050_0093));
    check("bypass_count", 96'(count), 96'(0));
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("bypass_bubble", 96'({id_valid, id_pc}), 96'(0));

    // Fill under stall
    step(1'b0, 1'b1, 32'h0000_00FC, mk_inst(32'hFC), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 32'h104 + 32'(4 * i), mk_inst(32'h104 + 32'(4 * i)), 1'b1, 1'b0);
    end
    check("full_count", 96'(count), 96'(4));
    check("full_if_ready", 96'(if_ready), 96'(0));
    check("full_hold_pc", 96'(id_pc), 96'(32'hFC));
    pcs[0] = 32'h104; pcs[1] = 32'h108; pcs[2] = 32'h10C; pcs[3] = 32'h110; pcs[4] = 32'h114;
    for (int i = 0; i < 5; i++) begin
      v = (i < 2);
      step(1'b0, v, 32'h114, mk_inst(32'h114), 1'b0, 1'b0);
      check("drain_pc", 96'({id_valid, id_pc}), 96'({1'b1, pcs[i]}));
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush at full with a push presented
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'h200 + 32'(4 * i), mk_inst(32'h200 + 32'(4 * i)), 1'b1, 1'b0);
    end
    check("pre_flush_count", 96'(count), 96'(4));
    step(1'b0, 1'b1, 32'h300, mk_inst(32'h300), 1'b1, 1'b1);
    check("flush_count", 96'(count), 96'(0));
    check("flush_out", 96'({id_valid, id_pc, id_inst}), 96'(0));
    check("flush_if_ready", 96'(if_ready), 96'(1));
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Simultaneous push and pop at count 2
    step(1'b0, 1'b1, 32'h400, mk_inst(32'h400), 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h404, mk_inst(32'h404), 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h408, mk_inst(32'h408), 1'b0, 1'b0);
    check("pushpop_count", 96'(count), 96'(2));
    check("pushpop_head", 96'(id_pc), 96'(32'h400));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    check("pushpop_empty", 96'(sb.size()), 96'(0));

    // Wrap-around with random stall and valid
    sent = 0;
    cyc  = 0;
    while (sent < 3 * DEPTH + 1 && cyc < 400) begin
      v  = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      if (v && m_count != DEPTH) begin
        step(1'b0, 1'b1, 32'h1000 + 32'(4 * sent), mk_inst(32'h1000 + 32'(4 * sent)), st, 1'b0);
        sent++;
      end else begin
        step(1'b0, v, 32'h1000 + 32'(4 * sent), mk_inst(32'h1000 + 32'(4 * sent)), st, 1'b0);
      end
      cyc++;
    end
    check("wrap_all_sent", 96'(sent), 96'(3 * DEPTH + 1));
    for (int i = 0; i < DEPTH + 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    check("wrap_no_loss", 96'(sb.size()), 96'(0));
    check("wrap_final_count", 96'(count), 96'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_if_id_queue
`default_nettype wire

// File: doc/if_id_queue.md
# if_id_queue

Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry instruction queue between fetch and decode. IF pushes {pc, inst} pairs with a valid/ready handshake. ID sees a registered {pc, inst} output that holds while ID stalls and drains to zero bubbles when the queue is empty. A flush (taken branch or artificial squash) empties the queue and zeroes the ID outputs in one cycle, so fetch can run ahead of decode without losing or duplicating instructions.

## Interface
Parameters:
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all queued and output instructions (branch or artificial)
- if_valid  in  1  IF presents a fetched instruction
- if_pc  in  ADDR_W  fetched PC
- if_inst  in  INST_W  fetched instruction
- if_ready  out  1  queue can accept this cycle; combinational, equals (count != DEPTH)
- id_stall  in  1  ID cannot accept a new instruction this cycle
- id_pc  out  ADDR_W  registered PC to decode
- id_inst  out  INST_W  registered instruction to decode
- id_valid  out  1  registered; 1 when id_pc/id_inst carry a real instruction, 0 for a bubble
- count  out  CNT_W  registered queue occupancy, excluding the output register

## Operation
- Push: occurs when if_valid && if_ready && !flush.
- Output advance: occurs when !id_stall && !flush. Output register loads the first matching source:
  - queue head, if count > 0; entry is popped;
  - bypassed push word, if count == 0 and a push occurs; word is not written to storage;
  - zero bubble otherwise: id_pc = 0, id_inst = 0, id_valid = 0.
- When id_stall = 1: output register holds. Pushes still enter storage until full.
- Simultaneous push and pop with count > 0: push goes to tail, head goes to output, count unchanged.
- When full: if_ready = 0 even if a pop occurs in the same cycle. No pass-through at full.
- flush has priority over push, pop and stall. Next cycle:
  - count = 0 and both pointers = 0;
  - id_pc = 0, id_inst = 0, id_valid = 0.
- rst has priority over flush and produces the same state. Reset values: id_pc 0, id_inst 0, id_valid 0, count 0, if_ready 1.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. Count is tracked separately, so full and empty are unambiguous.
- Storage contents are don't-care after reset or flush. Only pointers and count are cleared.

## Timing
- Latency with empty queue and no stall: if_pc/if_inst pushed at edge N appear on id_* after edge N. This matches the single-register pipeline.
- Latency with queued instructions: FIFO order, one instruction per non-stalled cycle.
- Bubble-on-stall-release: a cycle with !id_stall and an empty queue without a push yields id_valid = 0 and zero outputs. This replaces the old rule "stall[1] && !stall[2] → zero".
- flush or rst asserted mid-stall or at full: discards everything in one edge. A push presented in that same cycle is dropped.
- if_ready depends only on registered count. There is no combinational path from id_stall or flush to if_ready.

## Structure
- Shared defines (defines.v) gains:
  - IfqDepth, default DEPTH;
  - IfqEntryBus, the {pc, inst} width macro.
  - RstEnable and ZeroWord are reused.
- One sub-module, sync_fifo_ptr, with parameters WIDTH and DEPTH. It holds storage array, wrapping head/tail pointers and count, with push/pop/clear inputs.
- if_id_queue owns the bypass mux, bubble insertion and output register.
- Target size: about 200 lines total.

## Test plan
- Reset:
  - Stimulus: rst = 1 for 2 cycles with if_valid = 1.
  - Required: id_pc = 0, id_inst = 0, id_valid = 0, count = 0, if_ready = 1. Nothing is captured.
- Bypass:
  - Stimulus: empty queue, no stall; push pc 0x100/inst 0x00500093 at edge N.
  - Required: on id_* after edge N with id_valid = 1; count stays 0. At edge N+1 with no push, outputs are zero and id_valid = 0.
- Fill under stall:
  - Stimulus: id_stall = 1 with DEPTH = 4; push pcs 0x104, 0x108, 0x10C, 0x110, 0x114.
  - Required: first four accepted (count = 4). if_ready = 0 on the fifth, which is held by IF. Output holds the prior instruction.
  - Stimulus: release stall.
  - Required: id_pc 0x104, 0x108, 0x10C, 0x110, 0x114 on consecutive cycles.
- Flush at full:
  - Stimulus: count = 4, id_stall = 1; assert flush with if_valid = 1.
  - Required: next cycle count = 0, id_* = 0, id_valid = 0, if_ready = 1. The flush-cycle push is dropped.
- Wrap-around:
  - Stimulus: 3·DEPTH + 1 instructions with random id_stall and if_valid.
  - Required: scoreboard shows strict FIFO order and no loss or duplication.
- Simultaneous push/pop:
  - Stimulus: count = 2, if_valid = 1, no stall.
  - Required: count stays 2, head is delivered, new word is enqueued at tail.
